// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS controller: opcodes,
//          R-type funct codes, ALUcontrol codes and the sequencer state type.
// Ports:   none (package).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // True for every opcode the sequencer knows how to execute.
  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI)  || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Purpose: combinational {opcode, funct} -> ALUcontrol decode.
// Ports:
//   opcode_i      in  6  instruction [31:26]
//   funct_i       in  6  instruction [5:0]
//   alu_control_o out 4  ALU operation select
//   funct_legal_o out 1  0 only for an R-type with an unsupported funct
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_legal_o
);

  always_comb begin
    alu_control_o = ALU_AND;
    funct_legal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: funct_legal_o = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_control_o = ALU_ADD;
      OP_BEQ:                alu_control_o = ALU_SUB;
      default:               alu_control_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Purpose: multi-cycle sequencer for the MIPS datapath. Owns pc and the
//          instruction register, fetches over a req/valid port, and drives
//          the datapath control lines state by state.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   imem_req/imem_addr       fetch request and address (= pc)
//   imem_rdata/imem_valid    fetched word and its valid strobe
//   inst                     instruction register
//   RegDst..MemToReg         datapath controls (all registered)
//   alu_zero, mem_ready      datapath/sram status
//   pc, halt                 current pc, sticky illegal-opcode flag
//   dbg_state_o              current sequencer state
//
// Fetch handshake: imem_req is raised in FETCH and held, with imem_addr
// stable, until a rising edge samples imem_req=1 and imem_valid=1; that edge
// captures imem_rdata and drops imem_req. imem_valid is ignored otherwise.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] inst,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [3:0]  ALUcontrol,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemToReg,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        halt,
  output state_t      dbg_state_o
);

  state_t      state_q;
  logic [31:0] pc_q, inst_q;
  logic        imem_req_q, halt_q, legal_q;
  logic        reg_dst_q, reg_write_q, alu_src_q, mem_write_q, mem_read_q, mem_to_reg_q;
  logic [3:0]  alu_ctrl_q;

  // Level controls are decoded from the incoming word so they are already
  // valid during DECODE.
  logic [5:0] fetch_op;
  logic [3:0] fetch_alu;
  logic       fetch_funct_legal, fetch_legal;

  assign fetch_op = imem_rdata[31:26];

  alu_decoder u_alu_decoder (
    .opcode_i      (fetch_op),
    .funct_i       (imem_rdata[5:0]),
    .alu_control_o (fetch_alu),
    .funct_legal_o (fetch_funct_legal)
  );

  assign fetch_legal = fetch_funct_legal && opcode_known(fetch_op);

  logic [5:0]  op_q;
  logic [31:0] pc_plus4_d, br_target_d, jmp_target_d;

  assign op_q         = inst_q[31:26];
  assign pc_plus4_d   = pc_q + PC_STEP;
  assign br_target_d  = pc_plus4_d + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign jmp_target_d = {pc_plus4_d[31:28], inst_q[25:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      imem_req_q   <= 1'b0;
      halt_q       <= 1'b0;
      legal_q      <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= ALU_AND;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_req_q <= 1'b1;
          if (imem_req_q && imem_valid) begin
            inst_q       <= imem_rdata;
            imem_req_q   <= 1'b0;
            legal_q      <= fetch_legal;
            // An illegal word leaves every control at 0 on its way to HALT.
            reg_dst_q    <= fetch_legal && (fetch_op == OP_RTYPE);
            alu_src_q    <= fetch_legal && ((fetch_op == OP_LW) || (fetch_op == OP_SW) ||
                                            (fetch_op == OP_ADDI));
            alu_ctrl_q   <= fetch_legal ? fetch_alu : ALU_AND;
            mem_to_reg_q <= fetch_legal && (fetch_op == OP_LW);
            state_q      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal_q) begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end else if (op_q == OP_J) begin
            pc_q         <= jmp_target_d;
            imem_req_q   <= 1'b1;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= ALU_AND;
            mem_to_reg_q <= 1'b0;
            state_q      <= S_FETCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_RTYPE, OP_ADDI: begin
              reg_write_q <= 1'b1;
              state_q     <= S_WB;
            end
            OP_LW: begin
              mem_read_q <= 1'b1;
              state_q    <= S_MEM;
            end
            OP_SW: begin
              mem_write_q <= 1'b1;
              state_q     <= S_MEM;
            end
            OP_BEQ: begin
              pc_q         <= alu_zero ? br_target_d : pc_plus4_d;
              imem_req_q   <= 1'b1;
              reg_dst_q    <= 1'b0;
              alu_src_q    <= 1'b0;
              alu_ctrl_q   <= ALU_AND;
              mem_to_reg_q <= 1'b0;
              state_q      <= S_FETCH;
            end
            default: begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (op_q == OP_LW) begin
              reg_write_q <= 1'b1;
              state_q     <= S_WB;
            end else begin
              pc_q         <= pc_plus4_d;
              imem_req_q   <= 1'b1;
              reg_dst_q    <= 1'b0;
              alu_src_q    <= 1'b0;
              alu_ctrl_q   <= ALU_AND;
              mem_to_reg_q <= 1'b0;
              state_q      <= S_FETCH;
            end
          end
        end
        S_WB: begin
          reg_write_q  <= 1'b0;
          pc_q         <= pc_plus4_d;
          imem_req_q   <= 1'b1;
          reg_dst_q    <= 1'b0;
          alu_src_q    <= 1'b0;
          alu_ctrl_q   <= ALU_AND;
          mem_to_reg_q <= 1'b0;
          state_q      <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          halt_q  <= 1'b1;
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign RegDst      = reg_dst_q;
  assign RegWrite    = reg_write_q;
  assign ALUSrc      = alu_src_q;
  assign ALUcontrol  = alu_ctrl_q;
  assign MemWrite    = mem_write_q;
  assign MemRead     = mem_read_q;
  assign MemToReg    = mem_to_reg_q;
  assign pc          = pc_q;
  assign halt        = halt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
`timescale 1ns/1ps
module tb_mips_mc_controller;
  import mips_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_valid, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg;
  logic        alu_zero, mem_ready, halt;
  logic [31:0] imem_addr, imem_rdata, inst, pc;
  logic [3:0]  ALUcontrol;
  state_t      dbg_state;

  mips_mc_controller #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .inst(inst), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUcontrol(ALUcontrol),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc(pc), .halt(halt), .dbg_state_o(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int bad_strobe = 0;
  int rel_cyc = 0;
  int cap_cyc = 0;
  logic [31:0] exp_fetch_q[$];
  logic [10:0] exp_wb_q[$];   // {len[3:0], RegDst, MemToReg, ALUSrc, ALUcontrol[3:0]}
  logic [4:0]  exp_mem_q[$];  // {is_write, len[3:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic sb_fetch(input logic [31:0] act);
    logic [31:0] e;
    if (exp_fetch_q.size() == 0) begin
      n_checks++;
      $display("FAIL fetch_unexpected: got addr %h, none expected", act);
    end else begin
      e = exp_fetch_q.pop_front();
      check("fetch_addr", act, e);
    end
  endtask

  task automatic sb_wb(input logic [10:0] act);
    logic [10:0] e;
    if (exp_wb_q.size() == 0) begin
      n_checks++;
      $display("FAIL wb_unexpected: got %h, none expected", act);
    end else begin
      e = exp_wb_q.pop_front();
      check("wb_ctrl", 32'(act), 32'(e));
    end
  endtask

  task automatic sb_mem(input logic [4:0] act);
    logic [4:0] e;
    if (exp_mem_q.size() == 0) begin
      n_checks++;
      $display("FAIL mem_unexpected: got %h, none expected", act);
    end else begin
      e = exp_mem_q.pop_front();
      check("mem_burst", 32'(act), 32'(e));
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_valid) sb_fetch(imem_addr);
  end

  logic [3:0] rw_len = 4'd0;
  logic [6:0] rw_ctrl = 7'd0;
  always @(negedge clk) begin
    if (!rst_n) rw_len <= 4'd0;
    else if (RegWrite) begin
      if (rw_len == 4'd0) rw_ctrl <= {RegDst, MemToReg, ALUSrc, ALUcontrol};
      rw_len <= rw_len + 4'd1;
    end else if (rw_len != 4'd0) begin
      sb_wb({rw_len, rw_ctrl});
      rw_len <= 4'd0;
    end
  end

  logic [3:0] mem_len = 4'd0;
  logic       mem_is_wr = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) mem_len <= 4'd0;
    else if (MemRead || MemWrite) begin
      if (mem_len == 4'd0) mem_is_wr <= MemWrite;
      mem_len <= mem_len + 4'd1;
    end else if (mem_len != 4'd0) begin
      sb_mem({mem_is_wr, mem_len});
      mem_len <= 4'd0;
    end
  end

  always @(negedge clk) begin
    if ((RegWrite && MemWrite) || (MemRead && MemWrite) || (RegWrite && MemRead))
      bad_strobe <= bad_strobe + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin n_checks++; $display("FAIL fetch_req_timeout: imem_req=0 after %0d cycles, need 1", n); end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    imem_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_ctrl", 32'({halt, imem_req, RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // One instruction: fw idle fetch cycles, mw wait cycles in MEM. lat counts
  // from the first cycle imem_req is seen high to the next FETCH entry.
  task automatic issue(input logic [31:0] instr, input int fw, input int mw, input logic az, output int lat);
    int n;
    int start;
    alu_zero = az;
    wait_req();
    start = cyc;
    repeat (fw) begin @(posedge clk); #1; end
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(posedge clk); #1;
    cap_cyc = cyc;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check("inst_capture", inst, instr);
    if (instr[31:26] == OP_LW || instr[31:26] == OP_SW) begin
      n = 0;
      while (!(MemRead || MemWrite) && n < 10) begin @(posedge clk); #1; n++; end
      if (!(MemRead || MemWrite)) begin n_checks++; $display("FAIL mem_timeout: no strobe after %0d cycles, need 1", n); end
      repeat (mw) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    n = 0;
    while (!imem_req && !halt && n < 20) begin @(posedge clk); #1; n++; end
    lat = cyc - start;
  endtask

  task automatic run(input logic [31:0] instr, input int fw, input int mw, input logic az,
                     input logic [31:0] pc_now, input logic has_wb, input logic [6:0] wb_ctrl,
                     input logic has_mem, input logic [4:0] mem_exp,
                     input int exp_lat, input logic [31:0] pc_next);
    int lat;
    exp_fetch_q.push_back(pc_now);
    if (has_wb) exp_wb_q.push_back({4'd1, wb_ctrl});
    if (has_mem) exp_mem_q.push_back(mem_exp);
    issue(instr, fw, mw, az, lat);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("pc_next", pc, pc_next);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem_valid = 1'b0; imem_rdata = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // add $3,$1,$2 with imem_valid on the 3rd cycle after reset release
    run(32'h0022_1820, 1, 0, 1'b0, 32'h0, 1'b1, 7'b100_0010, 1'b0, 5'h0, 5, 32'h4);
    check("first_fetch_cycles", cap_cyc - rel_cyc, 3);
    // lw $2,8($1) with mem_ready low 2 cycles
    run(32'h8C22_0008, 0, 2, 1'b0, 32'h4, 1'b1, 7'b011_0010, 1'b1, {1'b0, 4'd3}, 7, 32'h8);
    // sw $2,12($1)
    run(32'hAC22_000C, 0, 0, 1'b0, 32'h8, 1'b0, 7'h0, 1'b1, {1'b1, 4'd1}, 4, 32'hC);
    // sub $4,$1,$2
    run(32'h0022_2022, 0, 0, 1'b0, 32'hC, 1'b1, 7'b100_0110, 1'b0, 5'h0, 4, 32'h10);
    // beq imm=-2 taken at 0x10
    run(32'h1022_FFFE, 0, 0, 1'b1, 32'h10, 1'b0, 7'h0, 1'b0, 5'h0, 3, 32'hC);
    // addi $5,$1,-1
    run(32'h2025_FFFF, 0, 0, 1'b0, 32'hC, 1'b1, 7'b001_0010, 1'b0, 5'h0, 4, 32'h10);
    // beq not taken at 0x10
    run(32'h1022_FFFE, 0, 0, 1'b0, 32'h10, 1'b0, 7'h0, 1'b0, 5'h0, 3, 32'h14);
    // and / or / slt
    run(32'h0022_3024, 0, 0, 1'b0, 32'h14, 1'b1, 7'b100_0000, 1'b0, 5'h0, 4, 32'h18);
    run(32'h0022_3825, 0, 0, 1'b0, 32'h18, 1'b1, 7'b100_0001, 1'b0, 5'h0, 4, 32'h1C);
    run(32'h0022_402A, 0, 0, 1'b0, 32'h1C, 1'b1, 7'b100_0111, 1'b0, 5'h0, 4, 32'h20);
    // j 0x100
    run(32'h0800_0040, 0, 0, 1'b0, 32'h20, 1'b0, 7'h0, 1'b0, 5'h0, 2, 32'h100);

    // opcode 0x3F -> halt, frozen; imem_valid driven high must be ignored
    run(32'hFC00_0000, 0, 0, 1'b0, 32'h100, 1'b0, 7'h0, 1'b0, 5'h0, 0, 32'h100);
    imem_valid = 1'b1;
    imem_rdata = 32'h0022_1820;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("halt_pc", pc, 32'h100);
      check("halt_flags", 32'({halt, imem_req, RegWrite, MemWrite, MemRead}), 32'b10000);
    end
    imem_valid = 1'b0;
    do_reset();

    // illegal R-type funct 0x21 -> halt
    run(32'h0022_2021, 0, 0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b0, 5'h0, 0, 32'h0);
    check("funct_halt", 32'({halt, imem_req}), 32'b10);
    check("funct_halt_state", 32'(dbg_state), 32'(S_HALT));
    do_reset();

    // beq backwards from 0 wraps to 0xFFFFFFFC; add there wraps to 0
    run(32'h1022_FFFE, 0, 0, 1'b1, 32'h0, 1'b0, 7'h0, 1'b0, 5'h0, 3, 32'hFFFF_FFFC);
    run(32'h0022_1820, 0, 0, 1'b0, 32'hFFFF_FFFC, 1'b1, 7'b100_0010, 1'b0, 5'h0, 4, 32'h0);
    run(32'h2025_FFFF, 0, 0, 1'b0, 32'h0, 1'b1, 7'b001_0010, 1'b0, 5'h0, 4, 32'h4);

    // sw at 0x4 aborted by reset in its second MEM cycle
    exp_fetch_q.push_back(32'h4);
    alu_zero = 1'b0;
    wait_req();
    imem_valid = 1'b1;
    imem_rdata = 32'hAC22_000C;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    n = 0;
    while (!MemWrite && n < 10) begin @(posedge clk); #1; n++; end
    check("abort_in_mem", 32'(MemWrite), 32'h1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({MemWrite, MemRead, RegWrite, imem_req}), 32'h0);
    check("abort_pc", pc, 32'h0);
    check("abort_state", 32'(dbg_state), 32'(S_FETCH));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // recovery after the abort
    run(32'h0022_1820, 0, 0, 1'b0, 32'h0, 1'b1, 7'b100_0010, 1'b0, 5'h0, 4, 32'h4);

    repeat (3) @(posedge clk);
    #1;
    check("fetch_q_empty", exp_fetch_q.size(), 0);
    check("wb_q_empty", exp_wb_q.size(), 0);
    check("mem_q_empty", exp_mem_q.size(), 0);
    check("no_strobe_overlap", bad_strobe, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
